// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; TX start bit appears two edges after an idle push.
// No backpressure: trmt while the FIFO is full is dropped, so callers watch tx_full.
module uart_tx #(
    parameter int BAUD_DIV = 2604,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       tx_full,
    output logic       tx_idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [11:0]   BAUD_RELOAD = 12'(BAUD_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);

    typedef enum logic {IDLE, TRANSMIT} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [9:0]    shift_reg;
    logic [11:0]   baud_cnt;
    logic [3:0]    bit_cnt;
    logic          done_pre;
    logic          push, pop, load, shift, done_nxt;
    logic          fifo_empty, expiry, last_bit;

    // Fullness uses the pre-edge count, so a push in the same cycle as a pop from a full FIFO is lost.
    assign fifo_empty = (count == '0);
    assign push       = trmt && (count != FULL_CNT);
    assign expiry     = (state == TRANSMIT) && (baud_cnt == '0);
    assign last_bit   = (bit_cnt == 4'd9);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (expiry) begin
                    if (last_bit) begin
                        done_nxt = 1'b1;
                        if (!fifo_empty) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            shift     = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // TX and tx_done sit one register behind the shifter so both share the same alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            done_pre  <= 1'b0;
            tx_done   <= 1'b0;
            TX        <= 1'b1;
        end else begin
            if (load) begin
                shift_reg <= {1'b1, mem[rd_ptr], 1'b0};
                baud_cnt  <= BAUD_RELOAD;
                bit_cnt   <= '0;
            end else if (state == TRANSMIT) begin
                if (expiry) begin
                    baud_cnt <= BAUD_RELOAD;
                    bit_cnt  <= bit_cnt + 4'd1;
                end else begin
                    baud_cnt <= baud_cnt - 1'b1;
                end
                if (shift) shift_reg <= {1'b1, shift_reg[9:1]};
            end
            done_pre <= done_nxt;
            tx_done  <= done_pre;
            TX       <= shift_reg[0];
        end
    end

    assign tx_full = (count == FULL_CNT);
    assign tx_idle = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_DIV=16, DEPTH=4; TX is logged every cycle and frames are checked afterwards.
module tb_uart_tx;
    localparam int B    = 16;
    localparam int F    = 10 * B;
    localparam int LOGN = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX, tx_done, tx_full, tx_idle;

    uart_tx #(.BAUD_DIV(B), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done),
        .tx_full (tx_full),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic tx_log [0:LOGN-1];
    int   done_q [$];
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cyc < LOGN) tx_log[cyc] = TX;
        if (tx_done) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame starting at cycle s: check first and last cycle of every bit.
    task automatic check_frame(input string tag, input logic [7:0] d, input int s);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s_b%0d_first", tag, i), 32'(tx_log[s + B*i]), 32'(f[i]));
            check($sformatf("%s_b%0d_last", tag, i), 32'(tx_log[s + B*i + B - 1]), 32'(f[i]));
        end
    endtask

    task automatic check_dones(input string tag, input int s, input int n);
        check($sformatf("%s_count", tag), 32'(done_q.size()), 32'(n));
        for (int k = 0; k < n; k++)
            if (k < done_q.size())
                check($sformatf("%s_cyc%0d", tag, k), 32'(done_q[k]), 32'(s + F*(k+1)));
    endtask

    initial begin
        int n, s, r, hi;
        logic [7:0] exp_b [6];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(TX), 32'h1);
        check("rst_done", 32'(tx_done), 32'h0);
        check("rst_full", 32'(tx_full), 32'h0);
        check("rst_idle", 32'(tx_idle), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        done_q.delete();

        // Single byte 0xA5
        trmt = 1'b1; tx_data = 8'hA5;
        @(negedge clk);
        trmt = 1'b0;
        n = cyc; s = n + 2;
        check("a5_idle_fall", 32'(tx_idle), 32'h0);
        repeat (F + 20) @(negedge clk);
        check("a5_pre_start", 32'(tx_log[s-1]), 32'h1);
        check_frame("a5", 8'hA5, s);
        check("a5_after", 32'(tx_log[s+F]), 32'h1);
        check_dones("a5_done", s, 1);
        check("a5_idle_end", 32'(tx_idle), 32'h1);

        // Back-to-back 00 FF 55 3C
        done_q.delete();
        trmt = 1'b1; tx_data = 8'h00;
        @(negedge clk);
        n = cyc; s = n + 2;
        tx_data = 8'hFF; @(negedge clk);
        tx_data = 8'h55; @(negedge clk);
        tx_data = 8'h3C; @(negedge clk);
        trmt = 1'b0;
        repeat (4*F + 20) @(negedge clk);
        check("b2b_pre_start", 32'(tx_log[s-1]), 32'h1);
        check_frame("b2b0", 8'h00, s);
        check_frame("b2b1", 8'hFF, s + F);
        check_frame("b2b2", 8'h55, s + 2*F);
        check_frame("b2b3", 8'h3C, s + 3*F);
        check("b2b_after", 32'(tx_log[s+4*F]), 32'h1);
        check_dones("b2b_done", s, 4);

        // Overflow: 0x10 is popped, 0x11..0x14 fill the FIFO, 0x15 is dropped
        done_q.delete();
        trmt = 1'b1; tx_data = 8'h10;
        @(negedge clk);
        n = cyc; s = n + 2;
        tx_data = 8'h11; @(negedge clk);
        tx_data = 8'h12; @(negedge clk);
        tx_data = 8'h13; @(negedge clk);
        check("ovf_not_full", 32'(tx_full), 32'h0);
        tx_data = 8'h14; @(negedge clk);
        check("ovf_full", 32'(tx_full), 32'h1);
        tx_data = 8'h15; @(negedge clk);
        trmt = 1'b0;
        check("ovf_still_full", 32'(tx_full), 32'h1);
        // Collision: push 0x99 on the edge that loads frame 2 from a full FIFO
        repeat (155) @(negedge clk);
        check("col_full_before", 32'(tx_full), 32'h1);
        trmt = 1'b1; tx_data = 8'h99;
        @(negedge clk);
        trmt = 1'b0;
        check("col_count_dm1", 32'(tx_full), 32'h0);
        trmt = 1'b1; tx_data = 8'h77;
        @(negedge clk);
        trmt = 1'b0;
        check("col_refill_full", 32'(tx_full), 32'h1);
        repeat (6*F + 20) @(negedge clk);
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h77};
        for (int k = 0; k < 6; k++)
            check_frame($sformatf("ovf%0d", k), exp_b[k], s + k*F);
        check("ovf_after", 32'(tx_log[s+6*F]), 32'h1);
        check_dones("ovf_done", s, 6);
        check("ovf_idle_end", 32'(tx_idle), 32'h1);

        // Mid-frame reset during data bit 3 (frame bit 4) of 0xC3
        done_q.delete();
        trmt = 1'b1; tx_data = 8'hC3;
        @(negedge clk);
        trmt = 1'b0;
        repeat (2 + 4*B + 8) @(negedge clk);
        check("c3_bit4_low", 32'(TX), 32'h0);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(TX), 32'h1);
        check("async_rst_idle", 32'(tx_idle), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        repeat (200) @(negedge clk);
        hi = 0;
        for (int i = r; i < r + 191; i++) hi += int'(tx_log[i]);
        check("post_rst_quiet", 32'(hi), 32'd191);
        check("post_rst_no_done", 32'(done_q.size()), 32'h0);
        check("post_rst_idle", 32'(tx_idle), 32'h1);
        check("post_rst_full", 32'(tx_full), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
